// File: rtl/enigma_rotor_stepper.sv
// Enigma three-rotor stepping controller: accepts one keypress per handshake and
// drives per-rotor step pulses, including the middle-rotor double step.
module enigma_rotor_stepper #(
   parameter int NOTCH_RIGHT  = 21,
   parameter int NOTCH_MIDDLE = 4,
   parameter int MAX_POS      = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_init_state,
   input  logic [4:0] init_left,
   input  logic [4:0] init_middle,
   input  logic [4:0] init_right,
   input  logic       key_valid,
   output logic       key_ready,
   output logic [2:0] rotor_step,
   output logic       step_done,
   output logic [7:0] pos_left,
   output logic [7:0] pos_middle,
   output logic [7:0] pos_right
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] STEP = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [4:0] MAX_P   = 5'(MAX_POS);
   localparam logic [4:0] NOTCH_R = 5'(NOTCH_RIGHT);
   localparam logic [4:0] NOTCH_M = 5'(NOTCH_MIDDLE);

   logic [1:0] state_reg;
   logic [2:0] step_reg;
   logic       done_reg;
   logic [2:0] step_next;

   // Rotor index matches rotor_step bit: 0 = right, 1 = middle, 2 = left.
   logic [4:0] pos_reg  [3];
   logic [4:0] init_pos [3];
   logic [4:0] load_val [3];
   logic [4:0] inc_val  [3];

   assign init_pos[0] = init_right;
   assign init_pos[1] = init_middle;
   assign init_pos[2] = init_left;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_rotor
         assign load_val[gi] = (init_pos[gi] > MAX_P) ? 5'd0 : init_pos[gi];
         assign inc_val[gi]  = (pos_reg[gi] == MAX_P) ? 5'd0 : pos_reg[gi] + 5'd1;
      end
   endgenerate

   // Notch decisions look only at pre-step positions, which yields the double step.
   assign step_next[0] = 1'b1;
   assign step_next[1] = (pos_reg[0] == NOTCH_R) || (pos_reg[1] == NOTCH_M);
   assign step_next[2] = (pos_reg[1] == NOTCH_M);

   assign key_ready = (state_reg == IDLE) && !load_init_state && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         step_reg  <= 3'b000;
         done_reg  <= 1'b0;
      end else if (load_init_state) begin
         state_reg <= IDLE;
         step_reg  <= 3'b000;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (key_valid) begin
                  step_reg  <= step_next;
                  state_reg <= STEP;
               end
            end
            STEP: begin
               step_reg  <= 3'b000;
               done_reg  <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               step_reg  <= 3'b000;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) pos_reg[i] <= 5'd0;
      end else if (load_init_state) begin
         for (int i = 0; i < 3; i++) pos_reg[i] <= load_val[i];
      end else if (state_reg == STEP) begin
         for (int i = 0; i < 3; i++) begin
            if (step_reg[i]) pos_reg[i] <= inc_val[i];
         end
      end
   end

   assign rotor_step = step_reg;
   assign step_done  = done_reg;
   assign pos_right  = {3'b000, pos_reg[0]};
   assign pos_middle = {3'b000, pos_reg[1]};
   assign pos_left   = {3'b000, pos_reg[2]};

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Bench for enigma_rotor_stepper: directed scenarios plus random loads/keys,
// checked against an arithmetic model of the Enigma stepping rules.
module tb_enigma_rotor_stepper;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load_init_state = 1'b0;
   logic [4:0] init_left = '0, init_middle = '0, init_right = '0;
   logic       key_valid = 1'b0;
   logic       key_ready;
   logic [2:0] rotor_step;
   logic       step_done;
   logic [7:0] pos_left, pos_middle, pos_right;

   int n_checks = 0;
   int n_fail = 0;
   int m_l = 0, m_m = 0, m_r = 0;   // model positions

   enigma_rotor_stepper dut (
      .clk(clk), .reset(reset), .load_init_state(load_init_state),
      .init_left(init_left), .init_middle(init_middle), .init_right(init_right),
      .key_valid(key_valid), .key_ready(key_ready), .rotor_step(rotor_step),
      .step_done(step_done), .pos_left(pos_left), .pos_middle(pos_middle),
      .pos_right(pos_right)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag);
      chk({tag, ".left"},   32'(pos_left),   32'(m_l));
      chk({tag, ".middle"}, 32'(pos_middle), 32'(m_m));
      chk({tag, ".right"},  32'(pos_right),  32'(m_r));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int l, input int m, input int r);
      init_left = 5'(l); init_middle = 5'(m); init_right = 5'(r);
      load_init_state = 1'b1;
      #1;
      chk("load.key_ready_low", 32'(key_ready), 32'd0);
      tick();
      load_init_state = 1'b0;
      m_l = (l > 25) ? 0 : l;
      m_m = (m > 25) ? 0 : m;
      m_r = (r > 25) ? 0 : r;
      #1;
      chk_pos("load.pos");
      chk("load.rotor_step", 32'(rotor_step), 32'd0);
      chk("load.step_done", 32'(step_done), 32'd0);
      chk("load.key_ready", 32'(key_ready), 32'd1);
      $display("load  init=(%0d,%0d,%0d) -> pos=(%0d,%0d,%0d)", l, m, r, pos_left, pos_middle, pos_right);
   endtask

   task automatic do_key();
      bit sl, sm;
      logic [2:0] exp_step;
      sm = (m_r == 21) || (m_m == 4);
      sl = (m_m == 4);
      exp_step = {sl, sm, 1'b1};
      chk("key.ready_idle", 32'(key_ready), 32'd1);
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("key.rotor_step", 32'(rotor_step), 32'(exp_step));
      chk("key.ready_step", 32'(key_ready), 32'd0);
      chk("key.done_early", 32'(step_done), 32'd0);
      tick();
      m_r = (m_r + 1) % 26;
      if (sm) m_m = (m_m + 1) % 26;
      if (sl) m_l = (m_l + 1) % 26;
      chk_pos("key.pos");
      chk("key.step_done", 32'(step_done), 32'd1);
      chk("key.step_clear", 32'(rotor_step), 32'd0);
      chk("key.ready_done", 32'(key_ready), 32'd0);
      tick();
      chk("key.done_clear", 32'(step_done), 32'd0);
      chk("key.ready_back", 32'(key_ready), 32'd1);
      $display("key   step=%b -> pos=(%0d,%0d,%0d)", exp_step, pos_left, pos_middle, pos_right);
   endtask

   initial begin
      // Reset state
      tick();
      chk("reset.key_ready", 32'(key_ready), 32'd0);
      chk("reset.rotor_step", 32'(rotor_step), 32'd0);
      chk_pos("reset.pos");
      reset = 1'b0;
      #1;
      chk("reset.ready_after", 32'(key_ready), 32'd1);

      // Single key from zero, wrap, notch and double step
      do_key();
      do_load(0, 0, 25);
      do_key();
      do_load(0, 3, 21);
      do_key();
      do_key();
      do_load(25, 4, 7);
      do_key();
      do_load(30, 26, 25);

      // Held key_valid for 9 cycles from (0,0,0)
      do_load(0, 0, 0);
      key_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("held.step_done", 32'(step_done), (i % 3 == 1) ? 32'd1 : 32'd0);
      end
      key_valid = 1'b0;
      m_r = 3;
      chk_pos("held.pos");
      $display("held  9 cycles -> pos=(%0d,%0d,%0d)", pos_left, pos_middle, pos_right);

      // Load during STEP aborts the step
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      init_left = 5'd2; init_middle = 5'd2; init_right = 5'd2;
      load_init_state = 1'b1;
      tick();
      m_l = 2; m_m = 2; m_r = 2;
      chk_pos("abort.pos");
      chk("abort.step_done", 32'(step_done), 32'd0);
      chk("abort.rotor_step", 32'(rotor_step), 32'd0);
      chk("abort.ready_low", 32'(key_ready), 32'd0);
      load_init_state = 1'b0;
      #1;
      chk("abort.ready_back", 32'(key_ready), 32'd1);
      tick();
      chk("abort.no_done", 32'(step_done), 32'd0);
      $display("abort load in STEP -> pos=(%0d,%0d,%0d)", pos_left, pos_middle, pos_right);

      // Async reset mid-STEP with nonzero positions
      do_load(3, 5, 7);
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      m_l = 0; m_m = 0; m_r = 0;
      chk_pos("areset.pos");
      chk("areset.rotor_step", 32'(rotor_step), 32'd0);
      chk("areset.step_done", 32'(step_done), 32'd0);
      chk("areset.key_ready", 32'(key_ready), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("areset.ready_after", 32'(key_ready), 32'd1);
      chk_pos("areset.pos_after");
      $display("reset mid-STEP -> pos=(%0d,%0d,%0d)", pos_left, pos_middle, pos_right);

      // Randomized loads (biased toward notches) and keypresses
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0)
               do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            else
               do_load($urandom_range(24, 26), $urandom_range(3, 4), $urandom_range(19, 21));
         end else begin
            do_key();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
